// File: rtl/wh_output_scheduler.sv
// Wormhole output-port scheduler: round-robin packet arbitration with a link lock
// held until the tail flit, gated by a downstream credit counter.
module wh_output_scheduler #(
    parameter int N       = 4,
    parameter int CREDITS = 4,
    parameter int PRI_RST = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N-1:0]                   req_valid,
    input  logic [N-1:0]                   req_last,
    output logic [N-1:0]                   req_ready,
    output logic                           out_valid,
    output logic                           out_last,
    output logic [N-1:0]                   out_sel,
    input  logic                           credit_in,
    output logic [$clog2(CREDITS+1)-1:0]   credits,
    output logic                           locked
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(CREDITS + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   credits_q, credits_d;
    logic [PW-1:0]   win;
    logic [PW-1:0]   win_inc;
    logic [PW:0]     scan_sum;
    logic            found;
    logic            fire;

    // Winner search: the owner while locked, otherwise the first valid input
    // scanning upward from the priority pointer with wrap-around.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        found    = 1'b0;
        win      = owner_q;
        scan_sum = '0;
        if (state_q == LOCKED) begin
            found = req_valid[owner_q];
        end else begin
            for (int k = 0; k < N; k++) begin
                scan_sum = {1'b0, ptr_q} + (PW+1)'(k);
                if (scan_sum >= (PW+1)'(N)) begin
                    scan_sum = scan_sum - (PW+1)'(N);
                end
                if (!found && req_valid[scan_sum[PW-1:0]]) begin
                    found = 1'b1;
                    win   = scan_sum[PW-1:0];
                end
            end
        end
    end

    assign fire      = !rst && found && (credits_q != '0);
    assign req_ready = fire ? (N'(1) << win) : '0;
    assign out_sel   = req_ready;
    assign out_valid = fire;
    assign out_last  = fire && req_last[win];
    assign win_inc   = (win == PW'(N - 1)) ? '0 : win + PW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (fire) begin
            if (req_last[win]) begin
                state_d = IDLE;
                ptr_d   = win_inc;
            end else if (state_q == IDLE) begin
                state_d = LOCKED;
                owner_d = win;
            end
        end
    end

    // Simultaneous consume and return cancel; a surplus return saturates at the buffer depth.
    always_comb begin
        credits_d = credits_q;
        if (fire && !credit_in) begin
            credits_d = credits_q - CW'(1);
        end else if (!fire && credit_in && (credits_q != CW'(CREDITS))) begin
            credits_d = credits_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= PW'(PRI_RST);
            owner_q   <= '0;
            credits_q <= CW'(CREDITS);
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            credits_q <= credits_d;
        end
    end

    assign credits = credits_q;
    assign locked  = (state_q == LOCKED);

`ifndef SYNTHESIS
    // Upstream returned more credits than the downstream buffer can hold.
    credit_overflow_a : assert property (@(posedge clk) disable iff (rst)
        !(credit_in && !fire && (credits_q == CW'(CREDITS))))
        else $warning("credit_in received with credit counter already at %0d", CREDITS);
`endif

endmodule

// File: doc/wh_output_scheduler.md
# wh_output_scheduler

Wormhole output-port scheduler for the NoC router. It shares one output link among N input ports at flit granularity. It picks a new packet owner with round-robin priority and holds the link for that owner until the tail flit has passed. A credit counter mirrors the free slots of the downstream buffer, and a flit moves only when at least one credit is available.

## Interface
- N, 4, number of input requesters (N >= 2)
- CREDITS, 4, depth of the downstream buffer and reset value of the credit counter (>= 1)
- PRI_RST, 0, input index holding highest priority after reset (0..N-1)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  N  input i presents a flit
- req_last  in  N  flit on input i is a packet tail (head==tail allowed)
- req_ready  out  N  one-hot or zero; flit of input i is consumed this cycle
- out_valid  out  1  flit transferred on the output link this cycle
- out_last  out  1  transferred flit is a tail
- out_sel  out  N  one-hot mux select of the winning input (zero when out_valid=0)
- credit_in  in  1  downstream freed one slot (one pulse per slot)
- credits  out  $clog2(CREDITS+1)  current credit count
- locked  out  1  link is owned by a packet in flight

## Operation
- Transfer condition: fire = grant to some input i AND req_valid[i] AND credits != 0. Then req_ready[i] = out_valid = 1, out_sel[i] = 1, out_last = req_last[i].
- State machine, two states:
  - IDLE:
    - Round-robin pick among req_valid, searched from priority pointer p: p, p+1, ..., N-1, 0, ..., p-1.
    - When credits == 0: no grant, no state change, and the pointer holds.
    - On fire with req_last=1: stay IDLE, p <= i+1 mod N.
    - On fire with req_last=0: go to LOCKED, owner <= i, p unchanged.
  - LOCKED:
    - Only the owner can be granted. Every other req_ready is 0 even when that input is valid.
    - Fire needs req_valid[owner] and credits != 0. Bubbles (owner invalid) keep the lock.
    - On a fire carrying a tail: go to IDLE, p <= owner+1 mod N.
- The arbiter outputs are combinational from the inputs and state. req_ready[i] depends on req_valid[i]. Upstream must not make req_valid depend on req_ready.
- Credit counter:
  - Decrements on fire, increments on credit_in.
  - Simultaneous fire and credit_in leave it unchanged.
  - If credit_in arrives with credits == CREDITS and no fire, the counter saturates at CREDITS. This is a protocol error and is flagged by a simulation assertion.
  - A fire with credits == 0 never occurs by construction.
- locked = (state == LOCKED).
- Tail-flit transfers are the only event that moves p. Pure-IDLE stalls and LOCKED bubbles never move it.

## Timing
- Reset values, held while rst=1:
  - State = IDLE.
  - p = PRI_RST.
  - credits = CREDITS.
  - locked = 0.
  - req_ready, out_valid, out_sel and out_last are all forced to 0 regardless of inputs.
- Grant latency is zero cycles: a valid flit with an available credit is transferred in the same cycle it is presented.
- State, pointer and credit updates take effect at the next rising edge.
- A credit_in pulse is usable one cycle later, so credits=0 plus credit_in in cycle t gives a possible fire in cycle t+1.
- Throughput is 1 flit/cycle while credits remain.
- With credit_in returning every cycle, CREDITS=1 gives full throughput only if the return is same-cycle. The design does not bypass credit_in: the credit must register first.
- Reset asserted mid-packet drops the lock and restores all reset values at that edge. The partial packet is lost and recovery is upstream's responsibility.

## Test plan
- Round-robin fairness, single-flit packets:
  - Stimulus: N=4, all req_valid=1 and req_last=1, credits ample, PRI_RST=0.
  - Required response: grants 0,1,2,3,0 on consecutive cycles.
- Lock hold:
  - Stimulus: input 2 sends a 3-flit packet while inputs 0, 1 and 3 are valid.
  - Required response: out_sel=0100 for exactly 3 fires, locked=1 after the head. Input 3 is granted next.
- Bubble in packet:
  - Stimulus: owner 1 drops req_valid for 2 cycles mid-packet while input 0 is valid.
  - Required response: no grant to input 0, locked stays 1, and the packet completes when owner 1 resumes.
- Credit exhaustion:
  - Stimulus: CREDITS=2, no credit_in, continuous traffic.
  - Required response: 2 fires, then req_ready=0 and credits=0. One credit_in pulse gives exactly 1 fire on the following cycle.
- Simultaneous fire and credit_in:
  - Stimulus: credits=1, fire together with credit_in.
  - Required response: credits stays 1.
  - Stimulus: credit_in at credits=CREDITS with no fire.
  - Required response: counter stays CREDITS and the assertion fires.
- Reset mid-packet:
  - Stimulus: rst=1 after 1 flit of a 4-flit packet from input 3, with PRI_RST=2.
  - Required response: locked=0, credits=CREDITS, and the first post-reset grant goes to input 2 if it is valid.
